// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
//   Posted-store buffer between the core data port and data memory. Core
//   stores are accepted in one cycle into an in-order FIFO and drained to
//   memory over a valid/ready write channel. Loads forward from the youngest
//   matching buffered store, otherwise memory read data passes through.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   cpu_we/addr/wdata       core store request, byte address, store data
//   cpu_rdata               load data to core (forwarded or memory)
//   cpu_stall               store refused this cycle (buffer full)
//   mem_wvalid/wready       drain handshake for the head entry
//   mem_waddr/wdata         head entry (word-aligned address, data)
//   mem_raddr/rdata         memory read port (address copy, read data)
//   empty, count            occupancy status
module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_we,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [DW-1:0]          cpu_wdata,
    output logic [DW-1:0]          cpu_rdata,
    output logic                   cpu_stall,
    output logic                   mem_wvalid,
    input  logic                   mem_wready,
    output logic [AW-1:0]          mem_waddr,
    output logic [DW-1:0]          mem_wdata,
    output logic [AW-1:0]          mem_raddr,
    input  logic [DW-1:0]          mem_rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-3:0] r_addr;
    logic [DEPTH-1:0][DW-1:0] r_data;
    logic [PW-1:0]            r_wptr;
    logic [PW-1:0]            r_rptr;
    logic [CW-1:0]            r_count;

    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic [DEPTH-1:0]         w_match;
    logic [DEPTH-1:0][DW-1:0] w_mdata;

    assign w_full     = (r_count == CW'(DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign mem_wvalid = ~empty;
    assign w_push     = cpu_we & ~w_full;
    assign w_pop      = mem_wvalid & mem_wready;
    assign cpu_stall  = cpu_we & w_full;
    assign mem_raddr  = cpu_addr;
    assign mem_waddr  = {r_addr[r_rptr], 2'b00};
    assign mem_wdata  = r_data[r_rptr];

    // Entries are compared in age order: slot g is the g-th oldest, counted
    // from the read pointer. Only the first r_count slots are occupied. The
    // store being pushed this cycle is not yet in storage, so it never forwards.
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        logic [PW-1:0] w_idx;
        assign w_idx      = r_rptr + PW'(g);
        assign w_match[g] = (CW'(g) < r_count) && (r_addr[w_idx] == cpu_addr[AW-1:2]);
        assign w_mdata[g] = r_data[w_idx];
    end

    // Later (younger) matches override earlier ones.
    always_comb begin
        cpu_rdata = mem_rdata;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i]) cpu_rdata = w_mdata[i];
        end
    end

    // Entry contents are cleared on reset only so that the head outputs are
    // never X; their value is meaningless while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_wptr] <= cpu_addr[AW-1:2];
                r_data[r_wptr] <= cpu_wdata;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer
//   Directed vectors with hand-computed expectations for dmem_write_buffer
//   (DEPTH=4, AW=DW=32). Inputs change 1 time unit after the rising edge;
//   outputs are compared before the next rising edge.
module tb_dmem_write_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        empty;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    dmem_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .empty      (empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_wready = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk("rst_empty",  32'(empty), 1);
        chk("rst_wvalid", 32'(mem_wvalid), 0);
        chk("rst_count",  32'(count), 0);
        chk("rst_stall",  32'(cpu_stall), 0);
        reset = 1'b0;
        tick();

        // single store then drain
        cpu_we = 1'b1; cpu_addr = 32'h64; cpu_wdata = 32'd7; #1;
        chk("t1_nostall", 32'(cpu_stall), 0);
        chk("t1_novld",   32'(mem_wvalid), 0);
        tick(); cpu_we = 1'b0; #1;
        chk("t1_wvalid", 32'(mem_wvalid), 1);
        chk("t1_waddr",  mem_waddr, 32'h64);
        chk("t1_wdata",  mem_wdata, 32'd7);
        chk("t1_count",  32'(count), 1);
        mem_wready = 1'b1; tick(); mem_wready = 1'b0; #1;
        chk("t1_empty",  32'(empty), 1);
        chk("t1_count0", 32'(count), 0);

        // fill, stall, pop frees a slot, stalled store accepted next cycle
        for (int i = 0; i < 4; i++) store(32'(4 * i), 32'(i + 1));
        chk("t2_full", 32'(count), 4);
        cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'd5; #1;
        chk("t2_stall", 32'(cpu_stall), 1);
        mem_wready = 1'b1; #1;
        chk("t2_stall_pop", 32'(cpu_stall), 1);
        tick(); mem_wready = 1'b0; #1;
        chk("t2_cnt3",   32'(count), 3);
        chk("t2_unstall", 32'(cpu_stall), 0);
        chk("t2_head",   mem_waddr, 32'h04);
        tick(); cpu_we = 1'b0; #1;
        chk("t2_cnt4", 32'(count), 4);
        mem_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_dr_addr", mem_waddr, 32'(4 * (i + 1)));
            chk("t2_dr_data", mem_wdata, 32'(i + 2));
            tick();
        end
        mem_wready = 1'b0; #1;
        chk("t2_empty", 32'(empty), 1);

        // forwarding: youngest of two same-word stores, miss passes memory
        store(32'hFC4, 32'h200);
        store(32'hFC4, 32'h400);
        cpu_addr = 32'hFC4; mem_rdata = 32'hDEAD; #1;
        chk("t3_fwd_young", cpu_rdata, 32'h400);
        cpu_addr = 32'hFC8; mem_rdata = 32'hAA; #1;
        chk("t3_miss", cpu_rdata, 32'hAA);
        chk("t3_raddr", mem_raddr, 32'hFC8);
        mem_wready = 1'b1; #1;
        chk("t3_dr0_a", mem_waddr, 32'hFC4);
        chk("t3_dr0_d", mem_wdata, 32'h200);
        tick();
        chk("t3_dr1_a", mem_waddr, 32'hFC4);
        chk("t3_dr1_d", mem_wdata, 32'h400);
        tick(); mem_wready = 1'b0; #1;
        chk("t3_empty", 32'(empty), 1);
        // a store being pushed this cycle does not forward
        cpu_we = 1'b1; cpu_addr = 32'h500; cpu_wdata = 32'h55; mem_rdata = 32'h99; #1;
        chk("t3_nopushfwd", cpu_rdata, 32'h99);
        cpu_we = 1'b0; #1;

        // streaming push+pop for 10 cycles, pointers wrap
        mem_wready = 1'b1; cpu_we = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cpu_addr = 32'h100 + 32'(4 * k); cpu_wdata = 32'h10 + 32'(k); #1;
            if (k > 0) begin
                chk("t4_waddr", mem_waddr, 32'h100 + 32'(4 * (k - 1)));
                chk("t4_count", 32'(count), 1);
            end
            tick();
        end
        cpu_we = 1'b0; #1;
        chk("t4_last", mem_waddr, 32'h124);
        tick(); mem_wready = 1'b0; #1;
        chk("t4_empty", 32'(empty), 1);

        // byte-offset load hits whole-word entry
        store(32'h64, 32'h1234);
        cpu_addr = 32'h66; mem_rdata = 32'h5555; #1;
        chk("t5_fwd_off", cpu_rdata, 32'h1234);
        chk("t5_raddr",   mem_raddr, 32'h66);

        // asynchronous reset with 3 entries pending
        store(32'h20, 32'h1);
        store(32'h24, 32'h2);
        chk("t6_cnt3", 32'(count), 3);
        #2 reset = 1'b1; #1;
        chk("t6_empty",  32'(empty), 1);
        chk("t6_wvalid", 32'(mem_wvalid), 0);
        chk("t6_count",  32'(count), 0);
        #1 reset = 1'b0;
        mem_wready = 1'b1;
        tick(); tick();
        chk("t6_nostale", 32'(mem_wvalid), 0);
        cpu_addr = 32'h64; mem_rdata = 32'h77; #1;
        chk("t6_nofwd", cpu_rdata, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Posted-store buffer between the single-cycle ARM core's data port (MemWrite/DataAdr/WriteData/ReadData) and data memory.
- Accepts word stores from the core in one cycle and queues them in an in-order FIFO.
- Drains the queue to memory over a valid/ready write channel, so the core does not wait on slow memory writes.
- Loads see the latest value at an address: the youngest matching buffered store is forwarded; otherwise memory read data passes through.

Parameters:
- DEPTH, 4, number of store entries; power of two, at least 2.
- AW, 32, byte address width.
- DW, 32, data word width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- cpu_we  input  1  core store request (core MemWrite)
- cpu_addr  input  AW  core byte address, used for stores and loads (core ALUResult)
- cpu_wdata  input  DW  core store data
- cpu_rdata  output  DW  load data returned to the core (forwarded or memory)
- cpu_stall  output  1  store not accepted this cycle; core must hold PC and the instruction
- mem_wvalid  output  1  head entry is valid for draining
- mem_wready  input  1  memory accepts the head entry at the rising edge
- mem_waddr  output  AW  head entry address, with bits [1:0] forced to 0
- mem_wdata  output  DW  head entry data
- mem_raddr  output  AW  combinational copy of cpu_addr for the memory read port
- mem_rdata  input  DW  combinational memory read data
- empty  output  1  no stores pending (fence/drain indication)
- count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage:
  - DEPTH entries, each holding {word address AW-2 bits, data DW}.
  - Write pointer, read pointer (each $clog2(DEPTH) bits, wrap modulo DEPTH) and occupancy counter.
- Reset (asynchronous):
  - Pointers and count go to 0, so empty=1, mem_wvalid=0 and cpu_stall=0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all pending stores; no partial drain completes after reset asserts.
- full = (count == DEPTH).
- Push happens at the rising edge when cpu_we & ~full.
  - It writes {cpu_addr[AW-1:2], cpu_wdata} at the write pointer and increments the write pointer.
- cpu_stall = cpu_we & full, combinational.
  - A stall holds for as many cycles as the buffer stays full.
  - No push occurs while full, even if a pop happens in the same cycle. The store is accepted on the next cycle, when count < DEPTH.
- Pop happens at the rising edge when mem_wvalid & mem_wready, and increments the read pointer.
- mem_wvalid = ~empty.
- mem_waddr and mem_wdata come directly from the head entry. They must stay stable while mem_wvalid=1 and mem_wready=0.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Push into an empty buffer: mem_wvalid rises on the following cycle. There is no bypass to memory in the same cycle, so minimum store-to-memory latency is 1 cycle.
- Drain order is strict FIFO. There is no coalescing: two stores to the same word both drain, oldest first.
- Load forwarding (combinational, every cycle, regardless of cpu_we):
  - Compare cpu_addr[AW-1:2] against every occupied entry.
  - If any match, cpu_rdata is the data of the youngest matching entry (closest to the write pointer).
  - If none match, cpu_rdata = mem_rdata.
  - Address bits [1:0] are ignored; whole-word forwarding only.
  - An entry being popped in the current cycle still participates in forwarding, since memory updates at the same edge.
  - The entry being pushed in the current cycle does not forward in that cycle.
- mem_raddr = cpu_addr at all times.
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0. The full/empty distinction comes from count, not from pointer equality.
- No X on outputs after reset. cpu_rdata may carry X only if mem_rdata is X and no entry matches.

Test Plan:
- Reset with mem_wready=0, then store (addr 0x64, data 7) -> next cycle: mem_wvalid=1, mem_waddr=0x64, mem_wdata=7, count=1; raise mem_wready for 1 cycle -> empty=1, count=0.
- mem_wready=0, four stores to 0x00,0x04,0x08,0x0C (data 1..4), then a fifth store to 0x10 -> count=4 and cpu_stall=1 on the fifth; mem_wready=1 for 1 cycle pops 0x00 with no push that cycle (stall persists); next cycle the fifth store is accepted, cpu_stall=0, count=4.
- Two stores to 0xFC4 (data 0x200 then 0x400), mem_wready=0, load cpu_addr=0xFC4 -> cpu_rdata=0x400; load 0xFC8 with mem_rdata=0xAA -> cpu_rdata=0xAA; drain -> memory sees 0x200 then 0x400 in order.
- Simultaneous push and pop for 10 cycles with mem_wready=1 and a store every cycle -> count stays at 1, pointers wrap past DEPTH, mem_waddr sequence equals the store sequence delayed by exactly 1 cycle.
- Load at 0x66 after a store to 0x64 (data 0x1234) -> cpu_rdata=0x1234, since bits [1:0] are ignored.
- Assert reset asynchronously with 3 entries pending mid-clock -> immediately empty=1, mem_wvalid=0, count=0; after release, no stale write appears on mem_wvalid.
